// File: rtl/ram_stream_reader.sv
// Sequential RAM read engine: credit-limited reads, FWFT response FIFO,
// valid/ready output stream with a last-word marker.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 512,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [ADDR_WIDTH-1:0] baseAddrIn,
  input  logic [ADDR_WIDTH:0]   lenIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic [ADDR_WIDTH-1:0] ramAddrOut,
  output logic                  ramRdEnOut,
  input  logic [DATA_WIDTH-1:0] ramRdDataIn,
  input  logic                  ramRdAckIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  input  logic                  readyIn,
  output logic                  lastOut
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_en_q, rd_en_d;
  logic [LW-1:0]           issue_left_q, issue_left_d;
  logic [LW-1:0]           out_left_q, out_left_d;
  logic [CW-1:0]           inflight_q, inflight_d;
  logic [CW-1:0]           count_q, count_d;
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic                    ack, pop, valid;
  logic [CW:0]             occ;

  assign valid = count_q != '0;
  assign pop   = valid & readyIn;
  // Acks outside an active command are stale and must not reach the FIFO
  assign ack   = ramRdAckIn & ((state_q == ISSUE) | (state_q == DRAIN));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = inflight_q + CW'(rd_en_q) - CW'(ack);
    count_d      = count_q + CW'(ack) - CW'(pop);
    if (rd_en_q) begin
      issue_left_d = issue_left_q - LW'(1);
      addr_d = (addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ?
               '0 : addr_q + ADDR_WIDTH'(1);
    end
    if (pop) out_left_d = out_left_q - LW'(1);
    unique case (state_q)
      IDLE: begin
        if (startIn) begin
          addr_d       = baseAddrIn;
          issue_left_d = lenIn;
          out_left_d   = lenIn;
          state_d      = (lenIn == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: if (issue_left_d == '0) state_d = DRAIN;
      DRAIN: if (pop && out_left_q == LW'(1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Credit check on next-cycle occupancy so an ack always finds room
    occ     = {1'b0, inflight_d} + {1'b0, count_d};
    rd_en_d = (state_d == ISSUE) && (issue_left_d != '0) &&
              (occ < (CW + 1)'(FIFO_DEPTH));
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rd_en_q      <= 1'b0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rd_en_q      <= rd_en_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      if (ack) begin
        mem_q[wr_ptr_q] <= ramRdDataIn;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign busyOut    = busy_q;
  assign doneOut    = done_q;
  assign ramAddrOut = addr_q;
  assign ramRdEnOut = rd_en_q;
  assign validOut   = valid;
  assign dataOut    = mem_q[rd_ptr_q];
  assign lastOut    = valid & (out_left_q == LW'(1));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a latency-configurable RAM
// model and per-word checks against the bench's own RAM image.
module tb_ram_stream_reader;

  localparam int DW = 32;
  localparam int RD = 512;
  localparam int FD = 4;
  localparam int AW = 9;

  logic          clkIn = 1'b0;
  logic          rstIn;
  logic          startIn;
  logic [AW-1:0] baseAddrIn;
  logic [AW:0]   lenIn;
  logic          busyOut, doneOut;
  logic [AW-1:0] ramAddrOut;
  logic          ramRdEnOut;
  logic [DW-1:0] ramRdDataIn;
  logic          ramRdAckIn;
  logic [DW-1:0] dataOut;
  logic          validOut, readyIn, lastOut;

  logic [DW-1:0] ram [RD];
  logic          pv0, pv1;
  logic [AW-1:0] pa0, pa1;
  int            lat;
  logic          injAck;
  int            nvec = 0;
  int            nerr = 0;
  bit            ab;
  int            dc;
  int            rb;

  always #5 clkIn = ~clkIn;

  ram_stream_reader #(.DATA_WIDTH(DW), .RAM_DEPTH(RD), .FIFO_DEPTH(FD)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn),
    .baseAddrIn(baseAddrIn), .lenIn(lenIn),
    .busyOut(busyOut), .doneOut(doneOut),
    .ramAddrOut(ramAddrOut), .ramRdEnOut(ramRdEnOut),
    .ramRdDataIn(ramRdDataIn), .ramRdAckIn(ramRdAckIn),
    .dataOut(dataOut), .validOut(validOut), .readyIn(readyIn),
    .lastOut(lastOut)
  );

  // RAM read port model, ack latency 1 or 2
  always @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      pv0 <= 1'b0; pv1 <= 1'b0; pa0 <= '0; pa1 <= '0;
    end else begin
      pv0 <= ramRdEnOut; pa0 <= ramAddrOut;
      pv1 <= pv0;        pa1 <= pa0;
    end
  end
  assign ramRdAckIn  = injAck | ((lat == 1) ? pv0 : pv1);
  assign ramRdDataIn = ram[(lat == 1) ? pa0 : pa1];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_busy"},  busyOut, 0);
    chk({pfx, "_done"},  doneOut, 0);
    chk({pfx, "_rden"},  ramRdEnOut, 0);
    chk({pfx, "_addr"},  ramAddrOut, 0);
    chk({pfx, "_valid"}, validOut, 0);
    chk({pfx, "_data"},  dataOut, 0);
    chk({pfx, "_last"},  lastOut, 0);
  endtask

  // Runs one command; rmode 0 = ready stuck high, 1 = random ready.
  // Returns early (aborted=1) once abort_at words have been accepted.
  task automatic run_cmd(input int base, input int len, input int rmode,
                         input int abort_at, input int restart_at,
                         output bit aborted, output int dcyc);
    int idx = 0, issued = 0, cyc = 0, lastx = -1;
    int lim = 8 * len + 40;
    bit stall = 0, done = 0;
    logic [DW-1:0] held = '0;
    aborted = 0;
    dcyc = -1;
    @(negedge clkIn);
    startIn = 1'b1;
    baseAddrIn = AW'(base);
    lenIn = (AW + 1)'(len);
    readyIn = 1'b0;
    while (!done) begin
      @(negedge clkIn);
      cyc++;
      startIn = 1'b0;
      if (cyc == restart_at) begin
        startIn = 1'b1;
        baseAddrIn = AW'(base + 37);
        lenIn = (AW + 1)'(3);
      end
      if (cyc == 1) begin
        chk("busy_at_start1", busyOut, 1);
        chk("rden_at_start1", ramRdEnOut, len != 0);
      end
      if (len == 0) chk("len0_no_valid", validOut, 0);
      if (ramRdEnOut) begin
        chk("rd_addr", ramAddrOut, (base + issued) % RD);
        issued++;
        chk("occupancy_le_depth", (issued - idx) <= FD, 1);
        chk("issue_le_len", issued <= len, 1);
      end
      if (stall && validOut) chk("stall_hold", dataOut, held);
      readyIn = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      stall = validOut && !readyIn;
      held = dataOut;
      if (validOut && readyIn) begin
        chk("data", dataOut, ram[(base + idx) % RD]);
        chk("last", lastOut, idx == len - 1);
        idx++;
        lastx = cyc;
        if (idx == abort_at) begin
          aborted = 1;
          return;
        end
      end
      if (doneOut) begin
        done = 1;
        dcyc = cyc;
        chk("done_word_count", idx, len);
        chk("done_after_last", cyc, (len == 0) ? 1 : lastx + 1);
      end
      if (cyc > lim) begin
        chk("timeout", cyc, lim);
        done = 1;
      end
    end
    readyIn = 1'b0;
    @(negedge clkIn);
    chk("idle_busy", busyOut, 0);
    chk("idle_done", doneOut, 0);
    chk("idle_valid", validOut, 0);
  endtask

  initial begin
    rstIn = 1'b1;
    startIn = 1'b0;
    baseAddrIn = '0;
    lenIn = '0;
    readyIn = 1'b0;
    injAck = 1'b0;
    lat = 1;
    for (int i = 0; i < RD; i++) ram[i] = 32'hA000_0000 + i;
    repeat (3) @(negedge clkIn);
    chk_zero("reset");
    rstIn = 1'b0;

    // basic read, full throughput
    run_cmd(16, 4, 0, 0, 0, ab, dc);
    chk("t1_done_latency", dc, 7);

    // backpressure, ack latency 2
    lat = 2;
    run_cmd(256, 16, 1, 0, 0, ab, dc);

    // address wrap
    lat = 1;
    run_cmd(RD - 2, 4, 1, 0, 0, ab, dc);

    // zero-length command
    run_cmd(5, 0, 0, 0, 0, ab, dc);
    chk("t4_done_cycle", dc, 1);

    // start while busy is ignored
    run_cmd(32, 6, 0, 0, 2, ab, dc);
    chk("t6_done_latency", dc, 9);

    // mid-command async reset
    run_cmd(128, 8, 1, 3, 0, ab, dc);
    @(posedge clkIn);
    #2 rstIn = 1'b1;
    #1 chk_zero("abort");
    repeat (3) begin
      @(negedge clkIn);
      chk("abort_no_done", doneOut, 0);
    end
    rstIn = 1'b0;
    @(negedge clkIn);
    injAck = 1'b1;
    @(negedge clkIn);
    injAck = 1'b0;
    chk("stale_ack_valid", validOut, 0);
    @(negedge clkIn);
    chk("stale_ack_valid2", validOut, 0);
    chk("stale_ack_busy", busyOut, 0);
    run_cmd(64, 2, 0, 0, 0, ab, dc);
    chk("t5a_done_latency", dc, 5);

    // full sweep with random contents and base
    for (int i = 0; i < RD; i++) ram[i] = $urandom;
    lat = 2;
    rb = int'($urandom_range(0, RD - 1));
    run_cmd(rb, RD, 1, 0, 0, ab, dc);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
